rgmii_link_ctrl: RTL and testbench

Link-status controller for the RGMII receive path. Decodes the PHY's RGMII in-band status, sent on RXD during inter-frame gaps, and debounces it. From the debounced status it drives the `link_speed` configuration shared by the RGMII PHY interface TX clock generator and RX nibble assembler. Sits in the `rgmii_mac_rx_clk` domain between the PHY interface's MAC-side RX outputs and every consumer of `link_speed`. Speed changes are deferred until no frame is in progress.

---
 rtl/rgmii_pkg.sv | 30 +++
 rtl/rgmii_inband_filter.sv | 74 +++++++
 rtl/rgmii_link_ctrl.sv | 154 +++++++++++++++
 tb/tb_rgmii_link_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// Shared RGMII link definitions: speed codes, in-band status layout, link FSM states.
package rgmii_pkg;

  localparam int unsigned SPEED_W  = 2;
  localparam int unsigned STATUS_W = 4;
  localparam int unsigned CNT_W    = 8;

  localparam logic [SPEED_W-1:0] SPEED_10   = 2'b00;
  localparam logic [SPEED_W-1:0] SPEED_100  = 2'b01;
  localparam logic [SPEED_W-1:0] SPEED_1000 = 2'b10;

  // Bit positions inside the in-band status nibble
  localparam int unsigned ST_LINK      = 0;
  localparam int unsigned ST_SPEED_LSB = 1;
  localparam int unsigned ST_DUPLEX    = 3;

  typedef logic [STATUS_W-1:0] status_t;

  typedef enum logic [1:0] {
    DOWN = 2'd0,
    UP   = 2'd1,
    PEND = 2'd2
  } link_state_t;

  // Extract the speed field from a status nibble
  function automatic logic [SPEED_W-1:0] st_speed(input status_t s);
    return s[ST_SPEED_LSB +: SPEED_W];
  endfunction

endpackage

// File: rtl/rgmii_inband_filter.sv
// Validates RGMII in-band status bytes and debounces them into a one-cycle qual pulse.
module rgmii_inband_filter
  import rgmii_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = 16
) (
  input  logic          rgmii_mac_rx_clk,
  input  logic          reset_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_dv,
  input  logic          rx_er,
  input  logic          rx_rdy,
  output logic          qual,
  output status_t       qual_status
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

  status_t          nib_c;
  logic             spd_ok_c;
  logic             smp_valid_c;
  logic             smp_vld;
  status_t          smp_st;
  status_t          cand;
  status_t          cand_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  assign nib_c    = rx_data[3:0];
  assign spd_ok_c = (st_speed(nib_c) == SPEED_10) || (st_speed(nib_c) == SPEED_100) ||
                    (st_speed(nib_c) == SPEED_1000);
  assign smp_valid_c = rx_rdy && !rx_dv && !rx_er && (rx_data[7:4] == rx_data[3:0]) && spd_ok_c;

  // Sample stage: capture each valid status nibble
  always_ff @(posedge rgmii_mac_rx_clk) begin
    if (!reset_n) begin
      smp_vld <= 1'b0;
      smp_st  <= '0;
    end else begin
      smp_vld <= smp_valid_c;
      if (smp_valid_c) smp_st <= nib_c;
    end
  end

  // Candidate/counter update; invalid samples leave both untouched
  always_comb begin
    cnt_d  = cnt;
    cand_d = cand;
    if (smp_vld) begin
      if (smp_st == cand) begin
        if (cnt != CNT_MAX) cnt_d = cnt + CNT_W'(1);
      end else begin
        cand_d = smp_st;
        cnt_d  = CNT_W'(1);
      end
    end
  end

  // Filter stage: counter state and qual pulse on reaching the threshold
  always_ff @(posedge rgmii_mac_rx_clk) begin
    if (!reset_n) begin
      cand <= '0;
      cnt  <= '0;
      qual <= 1'b0;
    end else begin
      cand <= cand_d;
      cnt  <= cnt_d;
      qual <= (cnt_d == CNT_MAX) && (cnt != CNT_MAX);
    end
  end

  assign qual_status = cand;

endmodule

// File: rtl/rgmii_link_ctrl.sv
// RGMII link-status controller: in-band status debounce, frame-deferred speed apply, force override.
module rgmii_link_ctrl
  import rgmii_pkg::*;
#(
  parameter int unsigned        STABLE_COUNT  = 16,
  parameter logic [SPEED_W-1:0] DEFAULT_SPEED = SPEED_1000
) (
  input  logic               rgmii_mac_rx_clk,
  input  logic               reset_n,
  input  logic [7:0]         rgmii_mac_rx_data,
  input  logic               rgmii_mac_rx_dv,
  input  logic               rgmii_mac_rx_er,
  input  logic               rgmii_mac_rx_rdy,
  input  logic               cfg_force_en,
  input  logic [SPEED_W-1:0] cfg_force_speed,
  output logic [SPEED_W-1:0] link_speed,
  output logic               link_up,
  output logic               full_duplex,
  output logic               speed_change,
  output logic               frame_active
);

  link_state_t        state;
  link_state_t        nxt;
  logic               qual;
  status_t            qual_status;
  status_t            pend;
  status_t            pend_d;
  status_t            applied;
  status_t            applied_d;
  logic               apply_c;
  status_t            apply_st_c;
  logic [SPEED_W-1:0] app_speed;
  logic [SPEED_W-1:0] app_speed_d;
  logic               app_duplex;
  logic               app_duplex_d;
  logic [SPEED_W-1:0] out_speed_c;
  logic               new_status_c;

  rgmii_inband_filter #(
    .STABLE_COUNT (STABLE_COUNT)
  ) u_filter (
    .rgmii_mac_rx_clk (rgmii_mac_rx_clk),
    .reset_n          (reset_n),
    .rx_data          (rgmii_mac_rx_data),
    .rx_dv            (rgmii_mac_rx_dv),
    .rx_er            (rgmii_mac_rx_er),
    .rx_rdy           (rgmii_mac_rx_rdy),
    .qual             (qual),
    .qual_status      (qual_status)
  );

  assign new_status_c = qual && (qual_status != applied);

  // Frame tracking from DV on each byte strobe
  always_ff @(posedge rgmii_mac_rx_clk) begin
    if (!reset_n)              frame_active <= 1'b0;
    else if (rgmii_mac_rx_rdy) frame_active <= rgmii_mac_rx_dv;
  end

  // FSM state register
  always_ff @(posedge rgmii_mac_rx_clk) begin
    if (!reset_n) state <= DOWN;
    else          state <= nxt;
  end

  // FSM next state
  always_comb begin
    nxt = state;
    case (state)
      DOWN: if (qual && qual_status[ST_LINK]) nxt = UP;
      UP: begin
        if (new_status_c) begin
          if (frame_active)                  nxt = PEND;
          else if (!qual_status[ST_LINK])    nxt = DOWN;
        end
      end
      PEND: begin
        if (!frame_active) nxt = (qual ? qual_status[ST_LINK] : pend[ST_LINK]) ? UP : DOWN;
      end
      default: nxt = DOWN;
    endcase
  end

  // FSM outputs: apply strobe, status to apply, pending status
  always_comb begin
    apply_c    = 1'b0;
    apply_st_c = qual_status;
    pend_d     = pend;
    case (state)
      DOWN: if (qual && qual_status[ST_LINK]) apply_c = 1'b1;
      UP: begin
        if (new_status_c) begin
          if (frame_active) pend_d  = qual_status;
          else              apply_c = 1'b1;
        end
      end
      PEND: begin
        if (qual) pend_d = qual_status;
        if (!frame_active) begin
          apply_c    = 1'b1;
          apply_st_c = qual ? qual_status : pend;
        end
      end
      default: ;
    endcase
  end

  // Applied-status datapath; speed/duplex hold their values on link loss
  always_comb begin
    applied_d    = applied;
    app_speed_d  = app_speed;
    app_duplex_d = app_duplex;
    if (apply_c) begin
      applied_d = apply_st_c;
      if (apply_st_c[ST_LINK]) begin
        app_speed_d  = st_speed(apply_st_c);
        app_duplex_d = apply_st_c[ST_DUPLEX];
      end
    end
    out_speed_c = cfg_force_en ? cfg_force_speed : app_speed_d;
  end

  // FSM-side status registers
  always_ff @(posedge rgmii_mac_rx_clk) begin
    if (!reset_n) begin
      pend       <= '0;
      applied    <= '0;
      app_speed  <= DEFAULT_SPEED;
      app_duplex <= 1'b0;
    end else begin
      pend       <= pend_d;
      applied    <= applied_d;
      app_speed  <= app_speed_d;
      app_duplex <= app_duplex_d;
    end
  end

  // Output registers with force override
  always_ff @(posedge rgmii_mac_rx_clk) begin
    if (!reset_n) begin
      link_speed   <= DEFAULT_SPEED;
      link_up      <= 1'b0;
      full_duplex  <= 1'b0;
      speed_change <= 1'b0;
    end else begin
      link_speed   <= out_speed_c;
      link_up      <= cfg_force_en || applied_d[ST_LINK];
      full_duplex  <= app_duplex_d;
      speed_change <= (out_speed_c != link_speed);
    end
  end

endmodule

// File: tb/tb_rgmii_link_ctrl.sv
// Scoreboard bench for rgmii_link_ctrl: directed stimulus pushes timed expectations, a negedge monitor checks them.
module tb_rgmii_link_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic       rx_er;
  logic       rx_rdy;
  logic       cfg_force_en;
  logic [1:0] cfg_force_speed;
  logic [1:0] link_speed;
  logic       link_up;
  logic       full_duplex;
  logic       speed_change;
  logic       frame_active;

  typedef struct {
    int         due;
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] obs;

  rgmii_link_ctrl #(
    .STABLE_COUNT  (16),
    .DEFAULT_SPEED (2'b10)
  ) dut (
    .rgmii_mac_rx_clk  (clk),
    .reset_n           (reset_n),
    .rgmii_mac_rx_data (rx_data),
    .rgmii_mac_rx_dv   (rx_dv),
    .rgmii_mac_rx_er   (rx_er),
    .rgmii_mac_rx_rdy  (rx_rdy),
    .cfg_force_en      (cfg_force_en),
    .cfg_force_speed   (cfg_force_speed),
    .link_speed        (link_speed),
    .link_up           (link_up),
    .full_duplex       (full_duplex),
    .speed_change      (speed_change),
    .frame_active      (frame_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (bits fa,sc,dup,up,spd[1:0])", tag, got, want);
  endtask

  // Compare every expectation that has come due at this cycle
  always @(negedge clk) begin
    obs = {2'b00, frame_active, speed_change, full_duplex, link_up, link_speed};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        chk(sb[i].tag, obs, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int dly, input string tag, input logic up, input logic [1:0] spd,
                           input logic dup, input logic sc, input logic fa);
    exp_t e;
    e.due = cyc + dly;
    e.tag = tag;
    e.val = {2'b00, fa, sc, dup, up, spd};
    sb.push_back(e);
  endtask

  task automatic step(input logic [7:0] d, input logic dv, input logic er, input logic rdy);
    rx_data = d;
    rx_dv   = dv;
    rx_er   = er;
    rx_rdy  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [3:0] nib, input int n);
    for (int i = 0; i < n; i++) step({nib, nib}, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, queue %0d want 0", sb.size());
    $fatal(1);
  end

  initial begin
    reset_n         = 1'b0;
    cfg_force_en    = 1'b0;
    cfg_force_speed = 2'b00;
    idle(2);
    reset_n = 1'b1;
    expect_at(0, "reset", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Basic qualification of 0xDD
    smp(4'hD, 16);
    expect_at(1, "basic_early", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    expect_at(2, "basic_qual",  1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Debounce restart and invalid samples ignored
    smp(4'h5, 15);
    smp(4'h3, 1);
    for (int i = 0; i < 15; i++) begin
      step(8'h55, 1'b0, 1'b0, 1'b1);
      step(8'h3D, 1'b0, 1'b0, 1'b1);
      step(8'hD7, 1'b0, 1'b0, 1'b1);
      step(8'h77, 1'b0, 1'b0, 1'b1);
      step(8'h55, 1'b0, 1'b1, 1'b1);
      step(8'h55, 1'b0, 1'b0, 1'b0);
    end
    expect_at(2, "dbnc_hold", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    idle(3);
    smp(4'h5, 1);
    expect_at(1, "dbnc_early", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    expect_at(2, "dbnc_qual",  1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Deferral: qual lands while a frame is in progress
    smp(4'h3, 16);
    step(8'hA5, 1'b1, 1'b0, 1'b1);
    expect_at(0, "dfr_start", 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(8'hA5, 1'b1, 1'b0, (i % 2) == 0);
      expect_at(0, "dfr_hold", 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    end
    step(8'h12, 1'b0, 1'b0, 1'b1);
    expect_at(0, "dfr_end",   1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    expect_at(1, "dfr_apply", 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    expect_at(2, "dfr_pulse", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Link down keeps speed and duplex
    smp(4'h0, 16);
    expect_at(1, "ldn_early", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(2, "ldn",       1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Re-qualify from DOWN, then force mid-frame
    smp(4'hD, 16);
    expect_at(2, "requal",    1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    expect_at(3, "requal_sc", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(8'hA5, 1'b1, 1'b0, 1'b1);
    expect_at(0, "frc_frame", 1'b1, 2'b10, 1'b1, 1'b0, 1'b1);
    cfg_force_en    = 1'b1;
    cfg_force_speed = 2'b00;
    step(8'hA5, 1'b1, 1'b0, 1'b1);
    expect_at(0, "frc_on",   1'b1, 2'b00, 1'b1, 1'b1, 1'b1);
    step(8'hA5, 1'b1, 1'b0, 1'b1);
    expect_at(0, "frc_hold", 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
    cfg_force_en = 1'b0;
    step(8'hA5, 1'b1, 1'b0, 1'b1);
    expect_at(0, "frc_rel",  1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
    step(8'hA5, 1'b1, 1'b0, 1'b1);
    expect_at(0, "frc_post", 1'b1, 2'b10, 1'b1, 1'b0, 1'b1);
    step(8'h12, 1'b0, 1'b0, 1'b1);
    expect_at(0, "frc_end",  1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Move to 100M for SDR pacing
    smp(4'h3, 16);
    expect_at(2, "to100",    1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    expect_at(3, "to100_sc", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    idle(3);

    // SDR pacing: rdy every other cycle, count is per rdy
    for (int i = 0; i < 16; i++) begin
      step(8'hBB, 1'b0, 1'b0, 1'b1);
      if (i == 14) expect_at(2, "sdr_15", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
      if (i == 15) begin
        expect_at(1, "sdr_early", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        expect_at(2, "sdr_qual",  1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
      end
      step(8'hBB, 1'b0, 1'b0, 1'b0);
    end
    idle(3);

    // Reset at SDR sample 10, then a full 16 samples are needed again
    for (int i = 0; i < 10; i++) begin
      if (i == 9) reset_n = 1'b0;
      step(8'h33, 1'b0, 1'b0, 1'b1);
      if (i == 9) begin
        expect_at(0, "sdr_rst", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
      end
      step(8'h33, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      step(8'h33, 1'b0, 1'b0, 1'b1);
      if (i == 14) expect_at(2, "rst_15", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
      if (i == 15) begin
        expect_at(1, "rst_early", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        expect_at(2, "rst_qual",  1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_at(3, "rst_sc",    1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
      end
      step(8'h33, 1'b0, 1'b0, 1'b0);
    end
    idle(4);

    for (int k = 0; k < 8 && sb.size() != 0; k++) idle(1);
    chk("sb_drain", 8'(sb.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
